pipeline_stall_controller: RTL

- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Detects load-use hazards that forwarding cannot cover.
- Freezes the pipeline while instruction or data memory is busy.
- Flushes IF/ID and ID/EX on a taken branch or jump.
- Drives the pipeline-register enable and clear controls and keeps saturating stall and flush performance counters.

---
 rtl/hazard_pkg.sv | 41 ++++
 rtl/sat_counter.sv | 20 ++
 rtl/pipeline_stall_controller.sv | 108 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall control.
// Holds the sequencer state encoding, control bundle and load-use detector.
package hazard_pkg;

   typedef enum logic [2:0] {
      RUN         = 3'd0,
      LOAD_BUBBLE = 3'd1,
      MEM_WAIT    = 3'd2
   } state_t;

   localparam logic [4:0]  REG_X0    = 5'd0;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic id_ex_stall;
      logic ex_mem_stall;
      logic mem_wb_stall;
      logic if_id_flush;
      logic id_ex_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE   = 7'b000_0000;
   localparam ctrl_t CTRL_MEM    = 7'b111_1100;
   localparam ctrl_t CTRL_BRANCH = 7'b000_0011;
   localparam ctrl_t CTRL_BUBBLE = 7'b110_0001;

   function automatic logic load_use(
      input logic       mem_read,
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       rs1_used,
      input logic       rs2_used
   );
      return mem_read && (rd != REG_X0) &&
             ((rs1_used && rd == rs1) || (rs2_used && rd == rs2));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && count != '1) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use bubbles,
// memory-busy freezes, taken-branch flushes and performance counters.
module pipeline_stall_controller
   import hazard_pkg::*;
#(
   parameter int LOAD_USE_STALLS = 1,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs1_address_id_stage,
   input  logic [4:0]       rs2_address_id_stage,
   input  logic             rs1_used_id,
   input  logic             rs2_used_id,
   input  logic [4:0]       rd_address_alu_stage,
   input  logic             mem_read_alu_stage,
   input  logic             branch_taken_alu_stage,
   input  logic             imem_busy,
   input  logic             dmem_busy,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             id_ex_stall,
   output logic             ex_mem_stall,
   output logic             mem_wb_stall,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [CNT_W-1:0] stall_cycle_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [2:0] BUB_INIT = 3'(LOAD_USE_STALLS - 1);

   state_t     state, state_n;
   logic [2:0] bub_cnt, bub_n;
   logic       resume, resume_n;
   logic       lu, lb_active;
   ctrl_t      ctrl;

   assign lu = load_use(mem_read_alu_stage, rd_address_alu_stage,
                        rs1_address_id_stage, rs2_address_id_stage,
                        rs1_used_id, rs2_used_id);

   // A wait that interrupted a bubble sequence continues it afterwards
   assign lb_active = (state == LOAD_BUBBLE) ||
                      (state == MEM_WAIT && resume);

   always_comb begin
      ctrl     = CTRL_NONE;
      state_n  = RUN;
      bub_n    = bub_cnt;
      resume_n = 1'b0;
      if (!reset) begin
         ctrl = CTRL_NONE;
      end else if (dmem_busy) begin
         ctrl     = CTRL_MEM;
         state_n  = MEM_WAIT;
         resume_n = lb_active;
      end else if (branch_taken_alu_stage) begin
         ctrl  = CTRL_BRANCH;
         bub_n = '0;
      end else if (lb_active) begin
         ctrl    = CTRL_BUBBLE;
         bub_n   = bub_cnt - 3'd1;
         state_n = (bub_cnt == 3'd1) ? RUN : LOAD_BUBBLE;
      end else if (lu) begin
         ctrl    = CTRL_BUBBLE;
         bub_n   = BUB_INIT;
         state_n = (BUB_INIT == 3'd0) ? RUN : LOAD_BUBBLE;
      end else if (imem_busy) begin
         ctrl = CTRL_BUBBLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= RUN;
         bub_cnt <= '0;
         resume  <= 1'b0;
      end else begin
         state   <= state_n;
         bub_cnt <= bub_n;
         resume  <= resume_n;
      end
   end

   assign pc_stall     = ctrl.pc_stall;
   assign if_id_stall  = ctrl.if_id_stall;
   assign id_ex_stall  = ctrl.id_ex_stall;
   assign ex_mem_stall = ctrl.ex_mem_stall;
   assign mem_wb_stall = ctrl.mem_wb_stall;
   assign if_id_flush  = ctrl.if_id_flush;
   assign id_ex_flush  = ctrl.id_ex_flush;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (pc_stall),
      .count (stall_cycle_count)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (if_id_flush),
      .count (flush_count)
   );

endmodule
